// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding and flag bit positions for the ALU operand sequencer
package alu_seq_pkg;
  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } seq_state_t;
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes an active-low raw button, debounces it and emits one pulse per accepted press
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, level, done;
  logic [CW-1:0] cnt;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  // cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) cnt <= '0;
      else if (done) begin
        level <= s2;
        cnt   <= '0;
        press <= ~s2;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: button-driven operand/opcode loader and result capture for the lab ALU
// Optional ALU_SEQ_CHAIN_EN: SHOW+next feeds the result back as operand A and resumes at LOAD_B.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int OP_MAX          = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw_data,
  input  logic [3:0]   sw_op,
  input  logic         btn_next,
  input  logic         btn_back,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic [N-1:0] res_q,
  output logic [3:0]   flags_q,
  output logic         res_valid,
  output logic         op_err,
  output logic [2:0]   state_code
);
  seq_state_t state, state_d;
  logic next_p, back_p, back_only;
  logic [N-1:0] a_d, b_d, res_d;
  logic [3:0] ctl_d, flags_d;
  logic valid_d, err_d;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst_n(rst_n), .raw(btn_next), .press(next_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk(clk), .rst_n(rst_n), .raw(btn_back), .press(back_p)
  );
  // next wins over a simultaneous back
  assign back_only  = back_p & ~next_p;
  assign state_code = state;
  always_comb begin
    state_d = state;
    a_d     = alu_a;
    b_d     = alu_b;
    ctl_d   = alu_control;
    res_d   = res_q;
    flags_d = flags_q;
    valid_d = res_valid;
    err_d   = 1'b0;
    case (state)
      LOAD_A: begin
        if (next_p) begin
          a_d     = sw_data;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (next_p) begin
          b_d     = sw_data;
          state_d = LOAD_OP;
        end else if (back_only) state_d = LOAD_A;
      end
      LOAD_OP: begin
        if (next_p) begin
          if (int'(sw_op) > OP_MAX) err_d = 1'b1;
          else begin
            ctl_d   = sw_op;
            state_d = EXEC;
          end
        end else if (back_only) state_d = LOAD_B;
      end
      EXEC: begin
        res_d   = alu_result;
        flags_d = alu_flags;
        valid_d = 1'b1;
        state_d = SHOW;
      end
      SHOW: begin
        if (next_p) begin
          valid_d = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
          a_d     = res_q;
          state_d = LOAD_B;
`else
          state_d = LOAD_A;
`endif
        end else if (back_only) begin
          valid_d = 1'b0;
          state_d = LOAD_OP;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD_A;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      res_valid   <= 1'b0;
      op_err      <= 1'b0;
    end else begin
      state       <= state_d;
      alu_a       <= a_d;
      alu_b       <= b_d;
      alu_control <= ctl_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      res_valid   <= valid_d;
      op_err      <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed vector bench with a behavioural 4-bit ALU attached
module tb_alu_operand_sequencer;
  logic clk = 0, rst_n = 0;
  logic [3:0] sw_data = 0, sw_op = 0;
  logic btn_next = 1, btn_back = 1;
  logic [3:0] alu_a, alu_b, alu_control, alu_result, alu_flags, res_q, flags_q;
  logic res_valid, op_err;
  logic [2:0] state_code;
  int checks = 0, errors = 0, err_cnt = 0, elen = 0;
  logic [2:0] prev = 0;
  logic [4:0] s;
  logic v;
  typedef struct {
    logic [3:0] a, b, op, res, flags;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  alu_operand_sequencer #(.N(4), .DEBOUNCE_CYCLES(4), .OP_MAX(9)) dut (
    .clk(clk), .rst_n(rst_n), .sw_data(sw_data), .sw_op(sw_op),
    .btn_next(btn_next), .btn_back(btn_back), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .alu_result(alu_result), .alu_flags(alu_flags),
    .res_q(res_q), .flags_q(flags_q), .res_valid(res_valid), .op_err(op_err),
    .state_code(state_code)
  );

  // attached ALU model: 0 add, 1 sub (carry = no borrow), 2 and, 3 or, 4 xor, else pass A
  always_comb begin
    s = {1'b0, alu_a};
    v = 1'b0;
    case (alu_control)
      4'd0: begin
        s = {1'b0, alu_a} + {1'b0, alu_b};
        v = (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3]);
      end
      4'd1: begin
        s = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        v = (alu_a[3] != alu_b[3]) && (s[3] != alu_a[3]);
      end
      4'd2: s = {1'b0, alu_a & alu_b};
      4'd3: s = {1'b0, alu_a | alu_b};
      4'd4: s = {1'b0, alu_a ^ alu_b};
      default: s = {1'b0, alu_a};
    endcase
    alu_result = s[3:0];
    alu_flags  = {v, s[4] && alu_control < 4'd2, s[3], s[3:0] == 4'd0};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic n, input logic b, input int hold);
    @(negedge clk);
    btn_next = ~n;
    btn_back = ~b;
    repeat (hold) @(negedge clk);
    btn_next = 1;
    btn_back = 1;
    repeat (10) @(negedge clk);
  endtask

  // EXEC must last one cycle with res_valid low, then SHOW with res_valid high
  always @(negedge clk) begin
    if (!rst_n) begin
      prev = 0;
      elen = 0;
    end else begin
      if (op_err) err_cnt++;
      if (state_code == 3'd3) begin
        elen++;
        chk("exec_valid_low", {31'b0, res_valid}, 0);
      end else if (prev == 3'd3) begin
        chk("exec_len", elen, 1);
        chk("show_after_exec", {29'b0, state_code}, 4);
        chk("valid_rise", {31'b0, res_valid}, 1);
        elen = 0;
      end
      prev = state_code;
    end
  end

  initial begin
    bit found;
    vt[0] = '{4'd3,  4'd5,  4'd0, 4'h8, 4'b1010};
    vt[1] = '{4'd5,  4'd5,  4'd1, 4'h0, 4'b0101};
    vt[2] = '{4'd6,  4'd3,  4'd2, 4'h2, 4'b0000};
    vt[3] = '{4'd9,  4'd6,  4'd3, 4'hF, 4'b0010};
    vt[4] = '{4'd15, 4'd1,  4'd0, 4'h0, 4'b0101};
    vt[5] = '{4'd7,  4'd9,  4'd1, 4'hE, 4'b1010};
    repeat (3) @(negedge clk);
    chk("rst_state", {29'b0, state_code}, 0);
    chk("rst_outs", {alu_a, alu_b, alu_control, res_q, flags_q, 2'b0, res_valid, op_err}, 0);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("idle_state", {29'b0, state_code}, 0);

    for (int i = 0; i < 6; i++) begin
      sw_data = vt[i].a;
      press(1, 0, 10);
      chk("load_a_state", {29'b0, state_code}, 1);
      chk("load_a_val", {28'b0, alu_a}, {28'b0, vt[i].a});
      sw_data = vt[i].b;
      press(1, 0, 10);
      chk("load_b_state", {29'b0, state_code}, 2);
      chk("load_b_val", {28'b0, alu_b}, {28'b0, vt[i].b});
      sw_op = vt[i].op;
      press(1, 0, 10);
      chk("show_state", {29'b0, state_code}, 4);
      chk("ctl", {28'b0, alu_control}, {28'b0, vt[i].op});
      chk("res_q", {28'b0, res_q}, {28'b0, vt[i].res});
      chk("flags_q", {28'b0, flags_q}, {28'b0, vt[i].flags});
      chk("res_valid", {31'b0, res_valid}, 1);
      press(1, 0, 10);
      chk("show_next_valid", {31'b0, res_valid}, 0);
`ifdef ALU_SEQ_CHAIN_EN
      chk("chain_state", {29'b0, state_code}, 1);
      chk("chain_a", {28'b0, alu_a}, {28'b0, vt[i].res});
      press(0, 1, 10);
`endif
      chk("show_next_state", {29'b0, state_code}, 0);
    end

    sw_data = 4'd2;
    press(1, 0, 10);
    sw_data = 4'd7;
    press(1, 0, 10);
    sw_op = 4'd10;
    err_cnt = 0;
    press(1, 0, 10);
    chk("op_err_pulses", err_cnt, 1);
    chk("op_err_state", {29'b0, state_code}, 2);
    chk("op_err_ctl", {28'b0, alu_control}, 1);
    press(0, 1, 10);
    chk("back_op_state", {29'b0, state_code}, 1);
    press(0, 1, 10);
    chk("back_b_state", {29'b0, state_code}, 0);
    chk("back_b_keep_a", {28'b0, alu_a}, 2);

    sw_data = 4'd11;
    @(negedge clk);
    btn_next = 0;
    repeat (2) @(negedge clk);
    btn_next = 1;
    repeat (12) @(negedge clk);
    chk("glitch_state", {29'b0, state_code}, 0);
    chk("glitch_a", {28'b0, alu_a}, 2);
    press(1, 0, 40);
    chk("long_press_state", {29'b0, state_code}, 1);
    chk("long_press_a", {28'b0, alu_a}, 11);
    sw_data = 4'd6;
    press(1, 1, 10);
    chk("simul_state", {29'b0, state_code}, 2);
    chk("simul_b", {28'b0, alu_b}, 6);
    press(0, 1, 10);
    press(0, 1, 10);
    chk("return_a", {29'b0, state_code}, 0);

`ifdef ALU_SEQ_CHAIN_EN
    sw_data = 4'd3;
    press(1, 0, 10);
    sw_data = 4'd5;
    press(1, 0, 10);
    sw_op = 4'd0;
    press(1, 0, 10);
    press(1, 0, 10);
    chk("chain1_a", {28'b0, alu_a}, 8);
    sw_data = 4'd1;
    press(1, 0, 10);
    press(1, 0, 10);
    chk("chain1_res", {28'b0, res_q}, 9);
    chk("chain1_flags", {28'b0, flags_q}, 4'b0010);
    press(1, 0, 10);
    press(0, 1, 10);
    chk("chain_exit", {29'b0, state_code}, 0);
`endif

    sw_data = 4'd3;
    press(1, 0, 10);
    sw_data = 4'd5;
    press(1, 0, 10);
    sw_op = 4'd0;
    @(negedge clk);
    btn_next = 0;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (state_code == 3'd3) found = 1;
    end
    chk("reach_exec", {31'b0, found}, 1);
    #1 rst_n = 0;
    #1;
    chk("rst_exec_state", {29'b0, state_code}, 0);
    chk("rst_exec_outs", {alu_a, alu_b, alu_control, res_q, flags_q, 2'b0, res_valid, op_err}, 0);
    btn_next = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (15) @(negedge clk);
    chk("post_rst_state", {29'b0, state_code}, 0);
    chk("post_rst_nocap", {27'b0, res_valid, res_q}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
